spi_byte_master: RTL

- Byte-level SPI mode-0 master engine for the SD/SPI device path.
- Derives SCLK from the system clock, drives CS_N and MOSI, and samples MISO.
- Delivers each received byte through a valid/ready holding register.
- Sits between the command sequencer upstream and the byte consumer downstream; it replaces per-bit clocking done by software or control logic.

---
 rtl/spi_byte_master_if.sv | 39 +++
 rtl/spi_byte_master.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master_if.sv
// Command, receive and SPI pin bundle for spi_byte_master.
// Under SPI_LSB_FIRST_EN the bundle also carries the per-command lsb_first select.
interface spi_byte_master_if;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       overrun;
   logic       clr_overrun;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       cs_n;
`ifdef SPI_LSB_FIRST_EN
   logic       lsb_first;
`endif

   // Engine side.
   modport master (
`ifdef SPI_LSB_FIRST_EN
      input  lsb_first,
`endif
      input  tx_data, tx_last, tx_valid, rx_ready, clr_overrun, miso,
      output tx_ready, rx_data, rx_valid, overrun, busy, sclk, mosi, cs_n
   );

   // Sequencer / consumer / SPI device side.
   modport slave (
`ifdef SPI_LSB_FIRST_EN
      output lsb_first,
`endif
      output tx_data, tx_last, tx_valid, rx_ready, clr_overrun, miso,
      input  tx_ready, rx_data, rx_valid, overrun, busy, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: divided SCLK, CS_N framing, valid/ready rx holding register.
// Optional macro SPI_LSB_FIRST_EN adds a per-command LSB-first bit order.
module spi_byte_master #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_SETUP = 1
) (
   input logic               clk,
   input logic               reset_n,
   spi_byte_master_if.master bus
);
   localparam int unsigned DIV_W  = 8;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned HALF_N = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_LOAD, S_HOLD, S_GAP
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div_cnt, w_div_cnt, w_div_step;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [7:0]       r_tx_sh, w_tx_sh;
   logic [7:0]       r_rx_sh, w_rx_sh;
   logic [7:0]       r_rx_data, w_rx_data;
   logic             r_last, w_last;
   logic             r_lsb, w_lsb;
   logic             r_sclk, w_sclk;
   logic             r_mosi, w_mosi;
   logic             r_cs_n, w_cs_n;
   logic             r_rx_valid, w_rx_valid;
   logic             r_overrun, w_overrun;
   logic             r_tx_ready;
   logic             r_busy;
   logic             w_accept;
   logic             w_tick;
   logic             w_lsb_req;

`ifdef SPI_LSB_FIRST_EN
   assign w_lsb_req = bus.lsb_first;
`else
   assign w_lsb_req = 1'b0;
`endif

   assign w_accept = bus.tx_valid && r_tx_ready;
   // Divider counts 1..CLK_DIV; the cleared value 0 adds one cycle to the first half-period.
   assign w_tick     = (r_div_cnt == DIV_W'(CLK_DIV));
   assign w_div_step = w_tick ? DIV_W'(1) : r_div_cnt + DIV_W'(1);

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
         S_SETUP: if (w_tick && (r_cnt == CNT_W'(CS_SETUP - 1))) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_tick && (r_cnt == CNT_W'(HALF_N - 1))) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = r_last ? S_HOLD : S_GAP;
         S_HOLD:  if (w_tick) w_state_nxt = S_IDLE;
         S_GAP:   if (w_accept) w_state_nxt = S_SHIFT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_div_cnt  = r_div_cnt;
      w_cnt      = r_cnt;
      w_tx_sh    = r_tx_sh;
      w_rx_sh    = r_rx_sh;
      w_rx_data  = r_rx_data;
      w_last     = r_last;
      w_lsb      = r_lsb;
      w_sclk     = r_sclk;
      w_mosi     = r_mosi;
      w_cs_n     = r_cs_n;
      w_rx_valid = r_rx_valid;
      w_overrun  = r_overrun;

      if (r_rx_valid && bus.rx_ready) w_rx_valid = 1'b0;
      if (bus.clr_overrun)            w_overrun  = 1'b0;

      case (r_state)
         S_IDLE, S_GAP: begin
            if (w_accept) begin
               w_tx_sh   = bus.tx_data;
               w_last    = bus.tx_last;
               w_lsb     = w_lsb_req;
               w_div_cnt = '0;
               w_cnt     = '0;
               w_cs_n    = 1'b0;
               w_mosi    = w_lsb_req ? bus.tx_data[0] : bus.tx_data[7];
            end
         end
         S_SETUP: begin
            w_div_cnt = w_div_step;
            if (w_tick) w_cnt = (r_cnt == CNT_W'(CS_SETUP - 1)) ? '0 : r_cnt + CNT_W'(1);
         end
         S_SHIFT: begin
            w_div_cnt = w_div_step;
            // Even half-period index ends with a rising SCLK edge, odd with a falling one.
            if (w_tick) begin
               w_sclk = ~r_sclk;
               w_cnt  = r_cnt + CNT_W'(1);
               if (!r_cnt[0]) begin
                  w_rx_sh = r_lsb ? {bus.miso, r_rx_sh[7:1]} : {r_rx_sh[6:0], bus.miso};
               end else begin
                  w_tx_sh = r_lsb ? {1'b1, r_tx_sh[7:1]} : {r_tx_sh[6:0], 1'b1};
                  w_mosi  = r_lsb ? r_tx_sh[1] : r_tx_sh[6];
               end
            end
         end
         S_LOAD: begin
            w_rx_data  = r_rx_sh;
            w_rx_valid = 1'b1;
            if (r_rx_valid && !bus.rx_ready) w_overrun = 1'b1;
            w_div_cnt  = DIV_W'(1);
         end
         S_HOLD: begin
            w_div_cnt = w_div_step;
            if (w_tick) w_cs_n = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_div_cnt  <= '0;
         r_cnt      <= '0;
         r_tx_sh    <= '0;
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_last     <= 1'b0;
         r_lsb      <= 1'b0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b1;
         r_cs_n     <= 1'b1;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
         r_tx_ready <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_div_cnt  <= w_div_cnt;
         r_cnt      <= w_cnt;
         r_tx_sh    <= w_tx_sh;
         r_rx_sh    <= w_rx_sh;
         r_rx_data  <= w_rx_data;
         r_last     <= w_last;
         r_lsb      <= w_lsb;
         r_sclk     <= w_sclk;
         r_mosi     <= w_mosi;
         r_cs_n     <= w_cs_n;
         r_rx_valid <= w_rx_valid;
         r_overrun  <= w_overrun;
         r_tx_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

   assign bus.tx_ready = r_tx_ready;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.overrun  = r_overrun;
   assign bus.busy     = r_busy;
   assign bus.sclk     = r_sclk;
   assign bus.mosi     = r_mosi;
   assign bus.cs_n     = r_cs_n;
endmodule
